// File: rtl/ysyx_23060201_gpr_wb_arb.sv
// GPR writeback arbiter: round-robin EXU/LSU grant into one registered write port,
// plus a busy-bit scoreboard for issue-time hazard detection.
module ysyx_23060201_gpr_wb_arb #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       exu_valid,
  output logic                       exu_ready,
  input  logic [ADDR_WIDTH-1:0]      exu_rd,
  input  logic [DATA_WIDTH-1:0]      exu_data,
  input  logic                       lsu_valid,
  output logic                       lsu_ready,
  input  logic [ADDR_WIDTH-1:0]      lsu_rd,
  input  logic [DATA_WIDTH-1:0]      lsu_data,
  output logic                       gpr_wen,
  output logic [ADDR_WIDTH-1:0]      gpr_waddr,
  output logic [DATA_WIDTH-1:0]      gpr_wdata,
  input  logic                       iss_valid,
  output logic                       iss_ready,
  input  logic [ADDR_WIDTH-1:0]      iss_rd,
  input  logic [ADDR_WIDTH-1:0]      chk_rs1,
  input  logic [ADDR_WIDTH-1:0]      chk_rs2,
  output logic                       rs1_busy,
  output logic                       rs2_busy,
  output logic [(1<<ADDR_WIDTH)-1:0] busy_vec
);

  localparam int unsigned NREG = 1 << ADDR_WIDTH;

  typedef enum logic {LAST_EXU, LAST_LSU} last_t;

  last_t                 last_q, last_d;
  logic                  grant_exu, grant_lsu, wb_xfer, iss_fire;
  logic [ADDR_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;
  logic [NREG-1:0]       busy_q, busy_d;

  // On contention the requester that did not win last time is granted.
  always_comb begin
    grant_exu = 1'b0;
    grant_lsu = 1'b0;
    if (rst) begin
      if (exu_valid && lsu_valid) begin
        grant_exu = (last_q == LAST_LSU);
        grant_lsu = (last_q == LAST_EXU);
      end else begin
        grant_exu = exu_valid;
        grant_lsu = lsu_valid;
      end
    end
  end

  assign exu_ready = grant_exu;
  assign lsu_ready = grant_lsu;
  assign wb_xfer   = grant_exu | grant_lsu;
  assign wb_rd     = grant_lsu ? lsu_rd   : exu_rd;
  assign wb_data   = grant_lsu ? lsu_data : exu_data;

  always_comb begin
    last_d = last_q;
    if (grant_exu)      last_d = LAST_EXU;
    else if (grant_lsu) last_d = LAST_LSU;
  end

  assign iss_ready = rst && !busy_q[iss_rd];
  assign iss_fire  = iss_valid && iss_ready;

  // Clear before set so a same-index issue wins over the writeback.
  always_comb begin
    busy_d = busy_q;
    if (wb_xfer)  busy_d[wb_rd]  = 1'b0;
    if (iss_fire) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q    <= '0;
      last_q    <= LAST_LSU;
      gpr_wen   <= 1'b0;
      gpr_waddr <= '0;
      gpr_wdata <= '0;
    end else begin
      busy_q  <= busy_d;
      last_q  <= last_d;
      gpr_wen <= wb_xfer && (wb_rd != '0);
      if (wb_xfer && (wb_rd != '0)) begin
        gpr_waddr <= wb_rd;
        gpr_wdata <= wb_data;
      end
    end
  end

  assign busy_vec = busy_q;

  // A write sitting in the output register is not yet in the GPR file.
  assign rs1_busy = (chk_rs1 != '0) && (busy_q[chk_rs1] || (gpr_wen && gpr_waddr == chk_rs1));
  assign rs2_busy = (chk_rs2 != '0) && (busy_q[chk_rs2] || (gpr_wen && gpr_waddr == chk_rs2));

endmodule
